// File: rtl/blackjack_pkg.sv
// Types and constants shared by the blackjack game logic and its card source.
package blackjack_pkg;

   typedef logic [3:0] rank_t;

   localparam int          DECK_SIZE = 52;
   localparam int          RANKS     = 13;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      READY,
      INIT,
      SHUFFLE
   } dealer_state_t;

   // Face cards count as ten; the result is already sized for the score buses.
   function automatic logic [5:0] rank_to_value(input rank_t rank);
      return (rank > rank_t'(10)) ? 6'd10 : {2'b00, rank};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps on every clock edge that is not in reset.
module lfsr16
   import blackjack_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] TAPS = LFSR_TAPS
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (reset)
         value <= SEED;
      else
         value <= {1'b0, value[15:1]} ^ (value[0] ? TAPS : 16'h0000);
   end

endmodule

// File: rtl/card_dealer.sv
// Card source for the blackjack game: deals a 52-card rank deck in order and
// reshuffles it in place with a Fisher-Yates pass driven by a free-running LFSR.
module card_dealer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          DECK_SIZE = 52
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       shuffle,
   input  logic       card_req,
   output logic       card_valid,
   output logic [3:0] card_rank,
   output logic [5:0] card_value,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy,
   output logic       req_err
);
   import blackjack_pkg::*;

   dealer_state_t state;
   dealer_state_t state_next;

   rank_t       deck [DECK_SIZE];
   logic [5:0]  ptr;
   logic [5:0]  idx;
   logic [15:0] lfsr_value;
   logic [5:0]  swap_sel;
   logic        unused_lfsr_bits;
   logic        do_deal;
   logic        do_swap;
   logic        drop_req;

   lfsr16 #(
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (lfsr_value)
   );

   assign swap_sel         = lfsr_value[5:0];
   assign unused_lfsr_bits = ^lfsr_value[15:6];

   always_ff @(posedge clk) begin
      if (reset)
         state <= READY;
      else
         state <= state_next;
   end

   // A shuffle command pre-empts everything, including a shuffle in progress.
   always_comb begin
      state_next = state;
      do_deal    = 1'b0;
      do_swap    = 1'b0;
      if (shuffle) begin
         state_next = INIT;
      end else begin
         case (state)
            READY: begin
               if (card_req && (cards_left != 6'd0))
                  do_deal = 1'b1;
            end
            INIT: begin
               state_next = SHUFFLE;
            end
            SHUFFLE: begin
               if (swap_sel <= idx) begin
                  do_swap = 1'b1;
                  if (idx == 6'd1)
                     state_next = READY;
               end
            end
            default: begin
               state_next = READY;
            end
         endcase
      end
      drop_req = card_req && !do_deal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DECK_SIZE; k++)
            deck[k] <= rank_t'((k % RANKS) + 1);
         ptr        <= 6'd0;
         idx        <= 6'd0;
         cards_left <= 6'(DECK_SIZE);
         card_valid <= 1'b0;
         card_rank  <= 4'd0;
         card_value <= 6'd0;
         req_err    <= 1'b0;
      end else begin
         card_valid <= do_deal;
         req_err    <= drop_req;
         if (state == INIT) begin
            for (int k = 0; k < DECK_SIZE; k++)
               deck[k] <= rank_t'((k % RANKS) + 1);
            ptr        <= 6'd0;
            cards_left <= 6'(DECK_SIZE);
            idx        <= 6'(DECK_SIZE - 1);
         end
         // A selection equal to the current slot is a harmless self-swap.
         if (do_swap) begin
            deck[idx]      <= deck[swap_sel];
            deck[swap_sel] <= deck[idx];
            idx            <= idx - 6'd1;
         end
         if (do_deal) begin
            card_rank  <= deck[ptr];
            card_value <= rank_to_value(deck[ptr]);
            ptr        <= ptr + 6'd1;
            cards_left <= cards_left - 6'd1;
         end
      end
   end

   assign deck_empty = (cards_left == 6'd0);
   assign busy       = (state != READY);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a deck-level model (whole Fisher-Yates
// pass planned at the moment a shuffle is accepted) plus directed scenarios.
module tb_card_dealer;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       shuffle = 1'b0;
   logic       card_req = 1'b0;
   logic       card_valid;
   logic [3:0] card_rank;
   logic [5:0] card_value;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;
   logic       req_err;

   int vectors = 0;
   int miscompares = 0;

   card_dealer #(
      .LFSR_SEED (SEED),
      .DECK_SIZE (52)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .shuffle    (shuffle),
      .card_req   (card_req),
      .card_valid (card_valid),
      .card_rank  (card_rank),
      .card_value (card_value),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .busy       (busy),
      .req_err    (req_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          model_ok = 1'b0;
   logic [15:0] m_lfsr;
   int          m_deck [52];
   int          plan_deck [52];
   int          m_ptr, m_left, m_busy_cnt, m_rank, m_value;
   bit          m_init_pend, m_valid, m_err;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Plays the whole shuffle out ahead of time; returns the number of shuffle steps.
   function automatic int plan_shuffle(input logic [15:0] cur);
      int i, j, n, t;
      logic [15:0] v;
      for (int k = 0; k < 52; k++) plan_deck[k] = (k % 13) + 1;
      v = lfsr_step(cur);
      i = 51;
      n = 0;
      while (n < 5000) begin
         n++;
         j = int'(v[5:0]);
         if (j <= i) begin
            t = plan_deck[i];
            plan_deck[i] = plan_deck[j];
            plan_deck[j] = t;
            if (i == 1) break;
            i--;
         end
         v = lfsr_step(v);
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (reset) begin
         m_lfsr      = SEED;
         m_ptr       = 0;
         m_left      = 52;
         m_busy_cnt  = 0;
         m_init_pend = 1'b0;
         m_rank      = 0;
         m_value     = 0;
         for (int k = 0; k < 52; k++) m_deck[k] = (k % 13) + 1;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_lfsr = lfsr_step(m_lfsr);
         if (shuffle) begin
            m_err       = card_req;
            m_busy_cnt  = plan_shuffle(m_lfsr) + 1;
            m_init_pend = 1'b1;
         end else if (m_busy_cnt > 0) begin
            m_err = card_req;
            if (m_init_pend) begin
               m_left      = 52;
               m_ptr       = 0;
               m_deck      = plan_deck;
               m_init_pend = 1'b0;
            end
            m_busy_cnt--;
         end else if (card_req) begin
            if (m_left > 0) begin
               m_valid = 1'b1;
               m_rank  = m_deck[m_ptr];
               m_value = (m_rank > 10) ? 10 : m_rank;
               m_ptr++;
               m_left--;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check_output("cmp_card_valid", card_valid, m_valid);
         check_output("cmp_req_err", req_err, m_err);
         check_output("cmp_busy", busy, (m_busy_cnt > 0) ? 1 : 0);
         check_output("cmp_cards_left", cards_left, m_left);
         check_output("cmp_deck_empty", deck_empty, (m_left == 0) ? 1 : 0);
         check_output("cmp_card_rank", card_rank, m_rank);
         check_output("cmp_card_value", card_value, m_value);
      end
   end

   // ---------------- directed stimulus ----------------
   int dealt [52];
   int dealt_cnt;

   task automatic apply_stimulus(input logic s, input logic r);
      shuffle  = s;
      card_req = r;
      @(negedge clk);
      shuffle  = 1'b0;
      card_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic deal_burst(input int n);
      dealt_cnt = 0;
      card_req  = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (card_valid === 1'b1 && dealt_cnt < 52) begin
            dealt[dealt_cnt] = int'(card_rank);
            dealt_cnt++;
         end
         if (i == n) card_req = 1'b0;
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_output("busy_drop_timeout", busy, 0);
   endtask

   initial begin
      int counts [14];
      int diff;
      int exp_value;

      @(negedge clk);
      do_reset();
      check_output("reset_busy", busy, 0);
      check_output("reset_cards_left", cards_left, 52);
      check_output("reset_card_valid", card_valid, 0);
      check_output("reset_card_rank", card_rank, 0);
      check_output("reset_deck_empty", deck_empty, 0);

      $display("[TB] ordered deals spaced two cycles apart");
      for (int k = 1; k <= 13; k++) begin
         apply_stimulus(1'b0, 1'b1);
         exp_value = (k > 10) ? 10 : k;
         check_output("ordered_strobe", card_valid, 1);
         check_output("ordered_rank", card_rank, k);
         check_output("ordered_value", card_value, exp_value);
         @(negedge clk);
      end
      check_output("ordered_cards_left", cards_left, 39);

      $display("[TB] draining the deck back-to-back");
      do_reset();
      deal_burst(52);
      check_output("drain_strobes", dealt_cnt, 52);
      check_output("drain_cards_left", cards_left, 0);
      check_output("drain_deck_empty", deck_empty, 1);
      check_output("drain_last_rank", dealt[51], 13);
      apply_stimulus(1'b0, 1'b1);
      check_output("empty_no_strobe", card_valid, 0);
      check_output("empty_req_err", req_err, 1);
      check_output("empty_still_empty", deck_empty, 1);

      $display("[TB] shuffle then deal full deck");
      apply_stimulus(1'b1, 1'b0);
      check_output("shuffle_busy", busy, 1);
      wait_ready();
      deal_burst(52);
      check_output("shuffled_strobes", dealt_cnt, 52);
      for (int r = 0; r < 14; r++) counts[r] = 0;
      for (int k = 0; k < dealt_cnt; k++)
         if (dealt[k] >= 0 && dealt[k] < 14) counts[dealt[k]]++;
      for (int r = 1; r <= 13; r++) check_output("shuffled_rank_count", counts[r], 4);
      diff = 0;
      for (int k = 0; k < 52; k++) if (dealt[k] != (k % 13) + 1) diff = 1;
      check_output("shuffled_differs", diff, 1);

      $display("[TB] request while busy");
      apply_stimulus(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      apply_stimulus(1'b0, 1'b1);
      check_output("busy_req_err", req_err, 1);
      check_output("busy_no_strobe", card_valid, 0);
      wait_ready();
      check_output("busy_cards_left", cards_left, 52);

      $display("[TB] shuffle and request together after ten deals");
      deal_burst(10);
      check_output("ten_cards_left", cards_left, 42);
      apply_stimulus(1'b1, 1'b1);
      check_output("collide_no_strobe", card_valid, 0);
      check_output("collide_req_err", req_err, 1);
      wait_ready();
      check_output("collide_cards_left", cards_left, 52);

      $display("[TB] reset in the middle of a shuffle");
      apply_stimulus(1'b1, 1'b0);
      repeat (10) @(negedge clk);
      check_output("mid_shuffle_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("midreset_busy", busy, 0);
      check_output("midreset_cards_left", cards_left, 52);
      check_output("midreset_no_strobe", card_valid, 0);
      apply_stimulus(1'b0, 1'b1);
      check_output("midreset_first_rank", card_rank, 1);
      check_output("midreset_first_value", card_value, 1);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
